uart_baud_gen: RTL and testbench

Programmable baud-rate tick generator for the UART datapath, replacing the fixed divide-by-651 divider. It produces an oversampled receive tick with a mid-bit strobe, and an independent one-per-bit transmit tick. The divisor is runtime-loadable, and the receive timebase can be re-phased by the receiver on a start-bit edge or on frame completion. It sits between the system clock and the uart_rx / uart_tx engines.

---
 rtl/uart_pkg.sv | 10 +
 rtl/uart_tick_prescaler.sv | 42 ++++
 rtl/uart_baud_gen.sv | 94 +++++++++
 tb/tb_uart_baud_gen.sv | 138 +++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART timebase constants
package uart_pkg;

    localparam int UART_DIV_W       = 16;
    localparam int UART_OVS         = 16;
    // 100 MHz system clock, 9600 baud, x16 oversampling
    localparam int UART_DEFAULT_DIV = 650;
    localparam int UART_SUB_W       = $clog2(UART_OVS);

endpackage

// File: rtl/uart_tick_prescaler.sv
// rtl/uart_tick_prescaler.sv - 0..div prescaler with wrap strobe and qualified registered tick
module uart_tick_prescaler
    import uart_pkg::*;
#(
    parameter int DIV_W = UART_DIV_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic             tick_qual_i,
    output logic             wrap_o,
    output logic             tick_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    // A clear or disable suppresses the wrap, so no tick escapes on that edge
    always_comb begin
        wrap_o = en_i && !clr_i && (cnt_q == div_i);
        cnt_d  = cnt_q + DIV_W'(1);
        if (!en_i || clr_i || wrap_o) begin
            cnt_d = '0;
        end
        tick_d = wrap_o && tick_qual_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - programmable rx oversample / tx bit tick generator
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int DIV_W       = UART_DIV_W,
    parameter int OVS         = UART_OVS,
    parameter int DEFAULT_DIV = UART_DEFAULT_DIV
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             div_wr_i,
    input  logic [DIV_W-1:0] div_in_i,
    input  logic             rx_resync_i,
    output logic             rx_tick_o,
    output logic             rx_mid_o,
    output logic             tx_tick_o,
    output logic [DIV_W-1:0] div_cur_o
);

    localparam int               SUB_W    = $clog2(OVS);
    localparam logic [SUB_W-1:0] MID_SUB  = SUB_W'(OVS / 2 - 1);
    localparam logic [SUB_W-1:0] LAST_SUB = SUB_W'(OVS - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [SUB_W-1:0] rx_sub_q, rx_sub_d;
    logic [SUB_W-1:0] tx_sub_q, tx_sub_d;
    logic             rx_mid_q, rx_mid_d;
    logic             rx_clr, tx_clr;
    logic             rx_wrap, tx_wrap;
    logic             tx_last;

    // A divisor load restarts both chains; resync only re-phases the receiver
    assign rx_clr  = div_wr_i || rx_resync_i;
    assign tx_clr  = div_wr_i;
    assign tx_last = (tx_sub_q == LAST_SUB);

    uart_tick_prescaler #(.DIV_W(DIV_W)) u_rx_pre (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .en_i        (en_i),
        .clr_i       (rx_clr),
        .div_i       (div_q),
        .tick_qual_i (1'b1),
        .wrap_o      (rx_wrap),
        .tick_o      (rx_tick_o)
    );

    uart_tick_prescaler #(.DIV_W(DIV_W)) u_tx_pre (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .en_i        (en_i),
        .clr_i       (tx_clr),
        .div_i       (div_q),
        .tick_qual_i (tx_last),
        .wrap_o      (tx_wrap),
        .tick_o      (tx_tick_o)
    );

    always_comb begin
        div_d    = div_wr_i ? div_in_i : div_q;
        rx_sub_d = rx_sub_q;
        tx_sub_d = tx_sub_q;
        if (!en_i || rx_clr) begin
            rx_sub_d = '0;
        end else if (rx_wrap) begin
            rx_sub_d = rx_sub_q + SUB_W'(1);
        end
        if (!en_i || tx_clr) begin
            tx_sub_d = '0;
        end else if (tx_wrap) begin
            tx_sub_d = tx_sub_q + SUB_W'(1);
        end
        rx_mid_d = rx_wrap && (rx_sub_q == MID_SUB);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q    <= DIV_W'(DEFAULT_DIV);
            rx_sub_q <= '0;
            tx_sub_q <= '0;
            rx_mid_q <= 1'b0;
        end else begin
            div_q    <= div_d;
            rx_sub_q <= rx_sub_d;
            tx_sub_q <= tx_sub_d;
            rx_mid_q <= rx_mid_d;
        end
    end

    assign rx_mid_o  = rx_mid_q;
    assign div_cur_o = div_q;

endmodule

// File: tb/tb_uart_baud_gen.sv
// tb/tb_uart_baud_gen.sv - directed self-checking bench for uart_baud_gen
module tb_uart_baud_gen;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        div_wr;
    logic [15:0] div_in;
    logic        rx_resync;
    logic        rx_tick;
    logic        rx_mid;
    logic        tx_tick;
    logic [15:0] div_cur;

    int n_tests = 0;
    int n_fail  = 0;

    uart_baud_gen dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .en_i        (en),
        .div_wr_i    (div_wr),
        .div_in_i    (div_in),
        .rx_resync_i (rx_resync),
        .rx_tick_o   (rx_tick),
        .rx_mid_o    (rx_mid),
        .tx_tick_o   (tx_tick),
        .div_cur_o   (div_cur)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic expect_at(input int k, input int first, input int per);
        return (per != 0) && (k >= first) && (((k - first) % per) == 0);
    endfunction

    // k counts rising edges after the current negedge; per==0 means never
    task automatic window(input string tag, input int n, input int rf, input int rp,
                          input int mf, input int mp, input int tf, input int tp);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            chk($sformatf("%s rx_tick k=%0d", tag, k), rx_tick, expect_at(k, rf, rp));
            chk($sformatf("%s rx_mid k=%0d", tag, k), rx_mid, expect_at(k, mf, mp));
            chk($sformatf("%s tx_tick k=%0d", tag, k), tx_tick, expect_at(k, tf, tp));
        end
    endtask

    task automatic load_div(input logic [15:0] d);
        div_wr = 1'b1;
        div_in = d;
        @(negedge clk);
        div_wr = 1'b0;
    endtask

    initial begin
        int found;
        rst_n     = 1'b0;
        en        = 1'b1;
        div_wr    = 1'b0;
        div_in    = '0;
        rx_resync = 1'b0;

        repeat (3) @(negedge clk);
        chk("reset div_cur", div_cur, 650);
        chk("reset rx_tick", rx_tick, 0);
        chk("reset rx_mid", rx_mid, 0);
        chk("reset tx_tick", tx_tick, 0);

        rst_n = 1'b1;
        found = 0;
        for (int k = 1; k <= 700; k++) begin
            @(negedge clk);
            if (rx_tick) begin
                found = k;
                break;
            end
        end
        chk("first rx_tick edge", found, 651);
        chk("first tick rx_mid", rx_mid, 0);
        chk("first tick tx_tick", tx_tick, 0);
        @(negedge clk);
        chk("tick one clock wide", rx_tick, 0);

        load_div(16'd3);
        chk("load3 div_cur", div_cur, 3);
        chk("load3 clear edge rx_tick", rx_tick, 0);
        window("div3", 130, 4, 4, 32, 64, 64, 64);

        load_div(16'd3);
        repeat (3) @(negedge clk);
        rx_resync = 1'b1;
        @(negedge clk);
        rx_resync = 1'b0;
        chk("resync suppresses wrap", rx_tick, 0);
        window("resync", 130, 4, 4, 32, 64, 60, 64);

        en = 1'b0;
        window("en_low", 10, 0, 0, 0, 0, 0, 0);
        en = 1'b1;
        window("en_restart", 130, 4, 4, 32, 64, 64, 64);

        load_div(16'd0);
        chk("load0 div_cur", div_cur, 0);
        chk("load0 clear edge rx_tick", rx_tick, 0);
        window("div0", 40, 1, 1, 8, 16, 16, 16);

        en = 1'b0;
        load_div(16'd5);
        chk("load while disabled div_cur", div_cur, 5);
        window("disabled", 10, 0, 0, 0, 0, 0, 0);
        en = 1'b1;
        window("div5", 100, 6, 6, 48, 96, 96, 96);

        load_div(16'd0);
        repeat (3) @(negedge clk);
        chk("pre-reset rx_tick high", rx_tick, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset rx_tick", rx_tick, 0);
        chk("async reset rx_mid", rx_mid, 0);
        chk("async reset tx_tick", tx_tick, 0);
        chk("async reset div_cur", div_cur, 650);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
